// File: rtl/adder_pkg.sv
// Shared constants and the Phase state encoding for the board adder entry sequencer.
// The testbench decodes Phase with the same enum.
package adder_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAVE_A = 2'd1,
        ADD    = 2'd2,
        SHOW   = 2'd3
    } phase_e;

endpackage

// File: rtl/adder_entry_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, and a one-cycle
// registered pulse on each accepted 0->1 level change.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic Clk,
    input  logic Rst,
    input  logic BtnRaw,
    output logic Press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          stable_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synced level agrees with the accepted level restarts the count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= BtnRaw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
            cnt_q         <= cnt_d;
        end
    end

    assign Press = press_q;

endmodule

// File: rtl/adder_entry_ctrl.sv
// Operator-entry sequencer for the 4-bit board adder: captures A then B from the
// switches on debounced presses, latches the datapath sum and flags a wrong sum.
module adder_entry_ctrl
    import adder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WIDTH           = adder_pkg::WIDTH
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [2*WIDTH-1:0] Sw,
    input  logic               Btn0,
    output logic [WIDTH-1:0]   AddA,
    output logic [WIDTH-1:0]   AddB,
    input  logic [WIDTH:0]     AddSum,
    output logic [WIDTH:0]     Output,
    output logic [1:0]         Phase,
    output logic               Valid,
    output logic               Err
);

    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    logic             press;
    phase_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH:0]   out_q;
    logic             valid_q, err_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
        .Clk    (Clk),
        .Rst    (Rst),
        .BtnRaw (Btn0),
        .Press  (press)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press) begin
                        a_q     <= Sw[WIDTH-1:0];
                        out_q   <= {1'b0, Sw[WIDTH-1:0]};
                        err_q   <= 1'b0;
                        state_q <= HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (press) begin
                        b_q     <= Sw[2*WIDTH-1:WIDTH];
                        state_q <= ADD;
                    end
                end
                // Operands have been on AddA/AddB for a full cycle, so AddSum is settled here.
                ADD: begin
                    out_q   <= AddSum;
                    valid_q <= 1'b1;
                    err_q   <= (AddSum != ref_sum(a_q, b_q));
                    state_q <= SHOW;
                end
                SHOW: begin
                    if (press) begin
                        a_q     <= Sw[WIDTH-1:0];
                        out_q   <= {1'b0, Sw[WIDTH-1:0]};
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= HAVE_A;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign AddA   = a_q;
    assign AddB   = b_q;
    assign Output = out_q;
    assign Phase  = state_q;
    assign Valid  = valid_q;
    assign Err    = err_q;

endmodule

// File: tb/tb_adder_entry_ctrl.sv
// Directed bench for adder_entry_ctrl with a short debounce window and a
// behavioural adder that can be forced to a wrong sum.
module tb_adder_entry_ctrl;
    import adder_pkg::*;

    localparam int D = 4;
    localparam int W = 4;

    logic           Clk = 1'b0;
    logic           Rst = 1'b1;
    logic [2*W-1:0] Sw = '0;
    logic           Btn0 = 1'b1;
    logic [W-1:0]   AddA, AddB;
    logic [W:0]     AddSum;
    logic [W:0]     Output;
    logic [1:0]     Phase;
    logic           Valid, Err;
    logic           fault = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int k;

    always #5 Clk = ~Clk;

    assign AddSum = fault ? 5'd7 : ({1'b0, AddA} + {1'b0, AddB});

    adder_entry_ctrl #(.DEBOUNCE_CYCLES(D), .WIDTH(W)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Sw     (Sw),
        .Btn0   (Btn0),
        .AddA   (AddA),
        .AddB   (AddB),
        .AddSum (AddSum),
        .Output (Output),
        .Phase  (Phase),
        .Valid  (Valid),
        .Err    (Err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Raise the button and count falling edges until Phase leaves its current value.
    task automatic press_wait(output int cycles);
        logic [1:0] start;
        start = Phase;
        Btn0 = 1'b1;
        cycles = 0;
        while (Phase == start && cycles < 60) begin
            @(negedge Clk);
            cycles++;
        end
        if (cycles >= 60) chk("press_timeout", 8'(cycles), 8'd0);
    endtask

    task automatic release_btn();
        Btn0 = 1'b0;
        repeat (D + 8) @(negedge Clk);
    endtask

    task automatic press_clean();
        int c;
        press_wait(c);
        release_btn();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_phase"}, 8'(Phase), 8'(IDLE));
        chk({tag, "_adda"}, 8'(AddA), 8'd0);
        chk({tag, "_addb"}, 8'(AddB), 8'd0);
        chk({tag, "_out"}, 8'(Output), 8'd0);
        chk({tag, "_valid"}, 8'(Valid), 8'd0);
        chk({tag, "_err"}, 8'(Err), 8'd0);
    endtask

    initial begin
        // 1: reset with button held, then exactly one press after release
        repeat (3) @(negedge Clk);
        chk_reset_vals("rst");
        Rst = 1'b0;
        press_wait(k);
        chk("held_latency", 8'(k), 8'(D + 4));
        chk("held_phase", 8'(Phase), 8'(HAVE_A));
        repeat (20) @(negedge Clk);
        chk("held_single", 8'(Phase), 8'(HAVE_A));
        release_btn();
        chk("release_nopress", 8'(Phase), 8'(HAVE_A));

        // 2: A=6, B=5 from a fresh IDLE
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        Sw = 8'hA6;
        press_clean();
        chk("a6_phase", 8'(Phase), 8'(HAVE_A));
        chk("a6_adda", 8'(AddA), 8'd6);
        chk("a6_out", 8'(Output), 8'd6);
        Sw = 8'h5F;
        press_wait(k);
        chk("add_phase", 8'(Phase), 8'(ADD));
        chk("add_addb", 8'(AddB), 8'd5);
        @(negedge Clk);
        chk("show_phase", 8'(Phase), 8'(SHOW));
        chk("sum11_out", 8'(Output), 8'd11);
        chk("sum11_valid", 8'(Valid), 8'd1);
        chk("sum11_err", 8'(Err), 8'd0);
        chk("sum11_adda", 8'(AddA), 8'd6);
        release_btn();
        chk("show_hold", 8'(Output), 8'd11);

        // 3: corner sums
        Sw = 8'hFF;
        press_clean();
        chk("ff_valid_clr", 8'(Valid), 8'd0);
        chk("ff_out_a", 8'(Output), 8'd15);
        press_clean();
        chk("sum30_out", 8'(Output), 8'd30);
        chk("sum30_err", 8'(Err), 8'd0);
        Sw = 8'h00;
        press_clean();
        press_clean();
        chk("sum0_out", 8'(Output), 8'd0);
        chk("sum0_valid", 8'(Valid), 8'd1);
        chk("sum0_phase", 8'(Phase), 8'(SHOW));

        // 4: bouncing button, one accepted press measured from steady high
        Sw = 8'h32;
        for (int i = 0; i < 3; i++) begin
            Btn0 = 1'b1;
            repeat (3) @(negedge Clk);
            Btn0 = 1'b0;
            @(negedge Clk);
        end
        chk("bounce_nopress", 8'(Phase), 8'(SHOW));
        press_wait(k);
        chk("bounce_latency", 8'(k), 8'(D + 4));
        chk("bounce_phase", 8'(Phase), 8'(HAVE_A));
        chk("bounce_adda", 8'(AddA), 8'd2);
        release_btn();
        chk("bounce_single", 8'(Phase), 8'(HAVE_A));

        // 5: faulty datapath, then recovery on the next entry
        fault = 1'b1;
        press_clean();
        chk("fault_out", 8'(Output), 8'd7);
        chk("fault_err", 8'(Err), 8'd1);
        chk("fault_valid", 8'(Valid), 8'd1);
        fault = 1'b0;
        press_clean();
        chk("recover_err", 8'(Err), 8'd0);
        chk("recover_valid", 8'(Valid), 8'd0);
        chk("recover_phase", 8'(Phase), 8'(HAVE_A));

        // 6: reset in HAVE_A and in ADD, then switch changes without a press
        Rst = 1'b1;
        @(negedge Clk);
        chk_reset_vals("rst_havea");
        Rst = 1'b0;
        Sw = 8'h9C;
        press_clean();
        chk("pre_add_adda", 8'(AddA), 8'd12);
        press_wait(k);
        chk("pre_rst_add", 8'(Phase), 8'(ADD));
        Rst = 1'b1;
        Btn0 = 1'b0;
        @(negedge Clk);
        chk_reset_vals("rst_add");
        Rst = 1'b0;
        Sw = 8'h7E;
        repeat (D + 8) @(negedge Clk);
        chk_reset_vals("sw_nopress");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
